// File: rtl/matmul_engine.sv
// Rectangular matrix multiplier C = A*B (or C += A*B), LANES output columns per cycle.
// Latency: 1 INIT + M*(P/LANES)*(K+1) MULTIPLY + 1 DONE cycle; start is ignored while busy.
// Optional build macro MATMUL_SIGNED_EN selects two's complement arithmetic (default unsigned).
module matmul_engine #(
  parameter int M          = 4,
  parameter int K          = 4,
  parameter int P          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 1,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(K)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   accumulate,
  input  logic [0:M-1][0:K-1][DATA_WIDTH-1:0]    A,
  input  logic [0:K-1][0:P-1][DATA_WIDTH-1:0]    B,
  output logic [0:M-1][0:P-1][ACC_WIDTH-1:0]     C,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   overflow
);

  localparam int NG  = P / LANES;
  localparam int PW  = 2 * DATA_WIDTH;
  localparam int RW  = (M > 1) ? $clog2(M) : 1;
  localparam int GW  = (NG > 1) ? $clog2(NG) : 1;
  localparam int KW  = $clog2(K + 1);
  localparam int KIW = (K > 1) ? $clog2(K) : 1;
  localparam int CW  = (P > 1) ? $clog2(P) : 1;

  generate
    if (P % LANES != 0) begin : g_lanes_check
      $error("matmul_engine: P must be a multiple of LANES");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_MULT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                                state_q, state_d;
  logic                                  mode_q;
  logic [RW-1:0]                         row_q;
  logic [GW-1:0]                         grp_q;
  logic [KW-1:0]                         k_q;
  logic [LANES-1:0][ACC_WIDTH-1:0]       acc_q;
  logic [0:M-1][0:P-1][ACC_WIDTH-1:0]    c_q;
  logic                                  ovf_q;

  // Plain-named views of the sequencer state, visible to hierarchical probes.
  logic [1:0]    state;
  logic [RW-1:0] row;
  logic [GW-1:0] grp;
  logic [KW-1:0] k;
  assign state = state_q;
  assign row   = row_q;
  assign grp   = grp_q;
  assign k     = k_q;

  logic                                  last_k, last_grp, last_row;
  logic [KIW-1:0]                        kidx;
  logic [LANES-1:0][CW-1:0]              col;
  logic [LANES-1:0][PW-1:0]              prod;
  logic [LANES-1:0][ACC_WIDTH-1:0]       acc_d;
  logic [LANES-1:0][ACC_WIDTH-1:0]       store_val;
  logic [LANES-1:0][ACC_WIDTH:0]         sum_w;
  logic                                  ovf_any;

  assign last_k   = (k == KW'(K));
  assign last_grp = (grp == GW'(NG - 1));
  assign last_row = (row == RW'(M - 1));
  // On the store cycle k==K is not a valid operand index; park it at 0.
  assign kidx     = last_k ? '0 : k[KIW-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state sequencing and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        busy    = 1'b1;
        state_d = S_MULT;
      end
      S_MULT: begin
        busy = 1'b1;
        if (last_k && last_grp && last_row) state_d = S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Per-lane product, accumulator update, store value and wrap detection.
  always_comb begin
    col       = '0;
    prod      = '0;
    acc_d     = '0;
    store_val = '0;
    sum_w     = '0;
    ovf_any   = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      col[l] = CW'(int'(grp) * LANES + l);
`ifdef MATMUL_SIGNED_EN
      prod[l]  = PW'($signed(A[row][kidx]) * $signed(B[kidx][col[l]]));
      acc_d[l] = acc_q[l] + ACC_WIDTH'($signed(prod[l]));
`else
      prod[l]  = PW'(A[row][kidx] * B[kidx][col[l]]);
      acc_d[l] = acc_q[l] + ACC_WIDTH'(prod[l]);
`endif
      sum_w[l]     = {1'b0, c_q[row][col[l]]} + {1'b0, acc_q[l]};
      store_val[l] = mode_q ? sum_w[l][ACC_WIDTH-1:0] : acc_q[l];
`ifdef MATMUL_SIGNED_EN
      // Signed overflow: carry into the sign bit differs from carry out of it.
      if (mode_q && (sum_w[l][ACC_WIDTH] ^ sum_w[l][ACC_WIDTH-1] ^
                     c_q[row][col[l]][ACC_WIDTH-1] ^ acc_q[l][ACC_WIDTH-1]))
        ovf_any = 1'b1;
`else
      if (mode_q && sum_w[l][ACC_WIDTH]) ovf_any = 1'b1;
`endif
    end
  end

  // Datapath: counters, lane accumulators, result array and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q <= 1'b0;
      row_q  <= '0;
      grp_q  <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) mode_q <= accumulate;
        S_INIT: begin
          row_q <= '0;
          grp_q <= '0;
          k_q   <= '0;
          acc_q <= '0;
          ovf_q <= 1'b0;
          if (!mode_q) c_q <= '0;
        end
        S_MULT: begin
          if (!last_k) begin
            acc_q <= acc_d;
            k_q   <= k_q + KW'(1);
          end else begin
            for (int l = 0; l < LANES; l++) c_q[row][col[l]] <= store_val[l];
            if (ovf_any) ovf_q <= 1'b1;
            acc_q <= '0;
            k_q   <= '0;
            if (last_grp) begin
              grp_q <= '0;
              row_q <= last_row ? '0 : row_q + RW'(1);
            end else begin
              grp_q <= grp_q + GW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign C        = c_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Directed self-checking bench for matmul_engine (LANES=1 and LANES=2 instances share stimulus).
module tb_matmul_engine;
  localparam int M  = 4;
  localparam int K  = 4;
  localparam int P  = 4;
  localparam int DW = 8;
  localparam int AW = 2*DW + $clog2(K);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, accumulate;
  logic [0:M-1][0:K-1][DW-1:0] a;
  logic [0:K-1][0:P-1][DW-1:0] b;
  logic [0:M-1][0:P-1][AW-1:0] c1, c2;
  logic busy1, done1, ovf1, busy2, done2, ovf2;

  int n_cmp = 0;
  int n_bad = 0;
  int e_done1, e_done2, nd;
  logic busy_dropped, busy_e0, ovf_after_init;
  logic [1:0] st_e0, st_e1;
  logic [AW-1:0] exp_c [M][P];

  matmul_engine #(.M(M), .K(K), .P(P), .DATA_WIDTH(DW), .LANES(1)) dut (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .A(a), .B(b), .C(c1), .busy(busy1), .done(done1), .overflow(ovf1));

  matmul_engine #(.M(M), .K(K), .P(P), .DATA_WIDTH(DW), .LANES(2)) dut2 (
    .clk(clk), .reset(reset), .start(start), .accumulate(accumulate),
    .A(a), .B(b), .C(c2), .busy(busy2), .done(done2), .overflow(ovf2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_ramp;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = DW'(i*4 + j);
        b[j][i] = DW'(i*4 + j);
      end
  endtask

  task automatic compute_expect(input logic acc);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) begin
        int s = 0;
        for (int kk = 0; kk < K; kk++) s += int'(a[i][kk]) * int'(b[kk][j]);
        exp_c[i][j] = acc ? exp_c[i][j] + AW'(s) : AW'(s);
      end
  endtask

  task automatic fill_expect(input logic [AW-1:0] v);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++) exp_c[i][j] = v;
  endtask

  function automatic int count_diff(input logic [0:M-1][0:P-1][AW-1:0] c);
    int d = 0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < P; j++)
        if (c[i][j] !== exp_c[i][j]) d++;
    return d;
  endfunction

  // Issue one start and follow the run until done on the LANES=1 instance (bounded).
  task automatic run_op(input logic acc, input bit mid_pulse);
    accumulate = acc;
    start = 1'b1;
    tick;
    start = 1'b0;
    st_e0 = dut.state;
    busy_e0 = busy1;
    e_done1 = -1;
    e_done2 = -1;
    busy_dropped = 1'b0;
    for (int n = 1; n <= 200 && e_done1 < 0; n++) begin
      if (!busy1) busy_dropped = 1'b1;
      start = (mid_pulse && n == 20);
      tick;
      if (n == 1) begin
        st_e1 = dut.state;
        ovf_after_init = ovf1;
      end
      if (done1 && e_done1 < 0) e_done1 = n;
      if (done2 && e_done2 < 0) e_done2 = n;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; accumulate = 1'b0; a = '0; b = '0;
    tick; tick;
    reset = 1'b0;
    n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", dut.state); end
    n_cmp++; if (c1 !== '0) begin n_bad++; $display("FAIL reset_c: got %h expected 0", c1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b expected 0", ovf1); end
  endtask

  task automatic test_basic;
    load_ramp;
    compute_expect(1'b0);
    run_op(1'b0, 1'b0);
    n_cmp++; if (st_e0 !== 2'd1) begin n_bad++; $display("FAIL basic_init_state: got %0d expected 1", st_e0); end
    n_cmp++; if (busy_e0 !== 1'b1) begin n_bad++; $display("FAIL basic_init_busy: got %b expected 1", busy_e0); end
    n_cmp++; if (st_e1 !== 2'd2) begin n_bad++; $display("FAIL basic_mult_state: got %0d expected 2", st_e1); end
    n_cmp++; if (e_done1 !== 81) begin n_bad++; $display("FAIL basic_done_edge: got %0d expected 81", e_done1); end
    n_cmp++; if (e_done2 !== 41) begin n_bad++; $display("FAIL lanes2_done_edge: got %0d expected 41", e_done2); end
    n_cmp++; if (busy_dropped !== 1'b0) begin n_bad++; $display("FAIL basic_busy_gap: got %b expected 0", busy_dropped); end
    n_cmp++; if (c1[0][0] !== AW'(14)) begin n_bad++; $display("FAIL basic_c00: got %0d expected 14", c1[0][0]); end
    n_cmp++; if (c1[1][1] !== AW'(126)) begin n_bad++; $display("FAIL basic_c11: got %0d expected 126", c1[1][1]); end
    n_cmp++; if (c1[2][2] !== AW'(366)) begin n_bad++; $display("FAIL basic_c22: got %0d expected 366", c1[2][2]); end
    n_cmp++; if (c1[3][3] !== AW'(734)) begin n_bad++; $display("FAIL basic_c33: got %0d expected 734", c1[3][3]); end
    n_cmp++; if (c1[0][3] !== AW'(86)) begin n_bad++; $display("FAIL basic_c03: got %0d expected 86", c1[0][3]); end
    n_cmp++; if (c1[1][2] !== AW'(214)) begin n_bad++; $display("FAIL basic_c12: got %0d expected 214", c1[1][2]); end
    nd = count_diff(c1);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL basic_full_c: %0d elements differ, expected 0", nd); end
    nd = count_diff(c2);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL lanes2_full_c: %0d elements differ, expected 0", nd); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL basic_ovf: got %b expected 0", ovf1); end
    tick;
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse: got %b expected 0", done1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL basic_busy_end: got %b expected 0", busy1); end
    n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL basic_idle: got %0d expected 0", dut.state); end
  endtask

  task automatic test_accumulate;
    compute_expect(1'b1);
    run_op(1'b1, 1'b1);
    n_cmp++; if (e_done1 !== 81) begin n_bad++; $display("FAIL acc_done_edge: got %0d expected 81", e_done1); end
    n_cmp++; if (c1[0][0] !== AW'(28)) begin n_bad++; $display("FAIL acc_c00: got %0d expected 28", c1[0][0]); end
    n_cmp++; if (c1[3][3] !== AW'(1468)) begin n_bad++; $display("FAIL acc_c33: got %0d expected 1468", c1[3][3]); end
    nd = count_diff(c1);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL acc_full_c: %0d elements differ, expected 0", nd); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL acc_ovf: got %b expected 0", ovf1); end
    tick;
  endtask

  task automatic test_overflow;
    logic [AW-1:0] v1, v2;
    logic ov2;
`ifdef MATMUL_SIGNED_EN
    v1 = AW'(4); v2 = AW'(8); ov2 = 1'b0;
`else
    v1 = AW'(260100); v2 = AW'(258056); ov2 = 1'b1;
`endif
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        a[i][j] = 8'hFF;
        b[i][j] = 8'hFF;
      end
    run_op(1'b0, 1'b0);
    tick;
    fill_expect(v1);
    nd = count_diff(c1);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL ovf_run1_c: %0d elements differ, c00 got %0d expected %0d", nd, c1[0][0], v1); end
    n_cmp++; if (ovf1 !== 1'b0) begin n_bad++; $display("FAIL ovf_run1_flag: got %b expected 0", ovf1); end
    run_op(1'b1, 1'b0);
    tick;
    fill_expect(v2);
    nd = count_diff(c1);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL ovf_run2_c: %0d elements differ, c00 got %0d expected %0d", nd, c1[0][0], v2); end
    n_cmp++; if (ovf1 !== ov2) begin n_bad++; $display("FAIL ovf_run2_flag: got %b expected %b", ovf1, ov2); end
    n_cmp++; if (ovf1 !== ov2) begin n_bad++; $display("FAIL ovf_sticky_idle: got %b expected %b", ovf1, ov2); end
    run_op(1'b0, 1'b0);
    n_cmp++; if (ovf_after_init !== 1'b0) begin n_bad++; $display("FAIL ovf_clear_init: got %b expected 0", ovf_after_init); end
    tick;
  endtask

  task automatic test_reset_mid;
    load_ramp;
    accumulate = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int n = 0; n < 21; n++) tick;
    n_cmp++; if (dut.state !== 2'd2) begin n_bad++; $display("FAIL midrst_pre_state: got %0d expected 2", dut.state); end
    reset = 1'b1;
    start = 1'b1;
    tick;
    reset = 1'b0;
    start = 1'b0;
    n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL midrst_state: got %0d expected 0", dut.state); end
    n_cmp++; if (c1 !== '0) begin n_bad++; $display("FAIL midrst_c: got %h expected 0", c1); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy1); end
    n_cmp++; if (done1 !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done1); end
    tick;
    n_cmp++; if (dut.state !== 2'd0) begin n_bad++; $display("FAIL midrst_start_dropped: got %0d expected 0", dut.state); end
    compute_expect(1'b0);
    run_op(1'b0, 1'b0);
    n_cmp++; if (e_done1 !== 81) begin n_bad++; $display("FAIL midrst_rerun_edge: got %0d expected 81", e_done1); end
    nd = count_diff(c1);
    n_cmp++; if (nd !== 0) begin n_bad++; $display("FAIL midrst_rerun_c: %0d elements differ, expected 0", nd); end
    tick;
  endtask

  task automatic test_signed;
    logic [AW-1:0] v;
`ifdef MATMUL_SIGNED_EN
    v = 18'h3FFFE;
`else
    v = AW'(510);
`endif
    a = '0;
    b = '0;
    a[0][0] = 8'hFF;
    b[0][0] = 8'd2;
    run_op(1'b0, 1'b0);
    n_cmp++; if (c1[0][0] !== v) begin n_bad++; $display("FAIL sign_c00: got %h expected %h", c1[0][0], v); end
    n_cmp++; if (c1[0][1] !== '0) begin n_bad++; $display("FAIL sign_c01: got %h expected 0", c1[0][1]); end
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_accumulate;
    test_overflow;
    test_reset_mid;
    test_signed;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
